// File: rtl/bakery_pkg.sv
// Shared types and default sizing for the bakery grant arbiter and its age matrix.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bakery_pkg;

    // Default sizing; NPROC must fit in IDXW bits and MAXHOLD must be >= 2.
    localparam int NPROC_DEF   = 3;
    localparam int IDXW_DEF    = 2;
    localparam int MAXHOLD_DEF = 8;

    // Arbiter sequencing: wait for an eligible ticket, hold the grant, then
    // spend one cycle retiring the holder before the next winner is chosen.
    typedef enum logic [1:0] {
        A_IDLE    = 2'd0,
        A_GRANT   = 2'd1,
        A_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bakery_age_matrix.sv
// Ticket/age bookkeeping: who holds a ticket, who is older than whom, and who was just served.
// Latency: ticket registered one edge after req; elig is combinational on registered state.
// Backpressure: none; requesters simply wait with req high until elig selects them.
module bakery_age_matrix
    import bakery_pkg::*;
#(
    parameter int NPROC = NPROC_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NPROC-1:0] req,
    input  logic [NPROC-1:0] clr,
    input  logic [NPROC-1:0] done,
    output logic [NPROC-1:0] ticket,
    output logic [NPROC-1:0] elig
);

    // defer[i][k] = 1: k already held a ticket when i took its own, so i yields to k.
    logic [NPROC-1:0][NPROC-1:0] defer;
    // served[i] = 1: i was released and has not yet dropped req since.
    logic [NPROC-1:0]            served;
    logic [NPROC-1:0]            take;

    // A new ticket needs a fresh request: not already queued, not just served.
    assign take = req & ~ticket & ~served;

    // Ticket, age-row and served-flag updates; leaving clears both row and column.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ticket <= '0;
            served <= '0;
            defer  <= '0;
        end else begin
            for (int i = 0; i < NPROC; i++) begin
                if (clr[i]) begin
                    ticket[i] <= 1'b0;
                    defer[i]  <= '0;
                end else if (take[i]) begin
                    // Snapshot of pre-edge holders, minus anyone leaving on this
                    // same edge; simultaneous takers never see each other.
                    ticket[i] <= 1'b1;
                    defer[i]  <= ticket & ~clr & ~(NPROC'(1) << i);
                end else begin
                    defer[i]  <= defer[i] & ~clr;
                end
                // A low req on the release edge itself already counts as the gap.
                served[i] <= (served[i] | done[i]) & req[i];
            end
        end
    end

    // Oldest ticket wins; equal-age tickets fall back to the lower index.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NPROC; i++) begin
            elig[i] = ticket[i];
            for (int k = 0; k < NPROC; k++) begin
                if (k != i && ticket[k] &&
                    (defer[i][k] || (!defer[k][i] && k < i))) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bakery_grant_arbiter.sv
// Bakery-order mutual-exclusion arbiter: one registered one-hot grant over NPROC requesters.
// Latency: req->ticket 1 edge, ticket->grant 1 edge when idle; 2-cycle gap between grants.
// Backpressure: holder keeps grant until rel, req drop, or MAXHOLD cycles (forced, timeout pulse).
module bakery_grant_arbiter
    import bakery_pkg::*;
#(
    parameter int NPROC   = NPROC_DEF,
    parameter int IDXW    = IDXW_DEF,
    parameter int MAXHOLD = MAXHOLD_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NPROC-1:0] req,
    input  logic [NPROC-1:0] rel,
    output logic [NPROC-1:0] grant,
    output logic [IDXW-1:0]  grant_idx,
    output logic             busy,
    output logic [NPROC-1:0] ticket,
    output logic             timeout
);

    localparam int CW = $clog2(MAXHOLD);

    arb_state_t       state;
    logic [IDXW-1:0]  hold_idx;
    logic [CW-1:0]    hold_cnt;
    logic [NPROC-1:0] elig;
    logic [IDXW-1:0]  win_idx;
    logic [NPROC-1:0] holder_mask;
    logic [NPROC-1:0] done;
    logic [NPROC-1:0] clr;
    logic             holder_rel;
    logic             holder_req;

    // The holder survives until the end of A_RELEASE so its ticket keeps
    // blocking everyone else through the hand-off cycle.
    assign holder_mask = (state != A_IDLE) ? (NPROC'(1) << hold_idx) : '0;
    assign done        = (state == A_RELEASE) ? holder_mask : '0;
    // Waiting requesters that drop req leave the queue; the holder leaves only via release.
    assign clr         = (~req & ticket & ~holder_mask) | done;
    // Only the holder's own rel/req matter; other rel bits are ignored.
    assign holder_rel  = |(rel & holder_mask);
    assign holder_req  = |(req & holder_mask);

    bakery_age_matrix #(
        .NPROC (NPROC)
    ) u_age (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .clr     (clr),
        .done    (done),
        .ticket  (ticket),
        .elig    (elig)
    );

    // Lowest set bit of elig; elig is one-hot by construction, this just encodes it.
    always_comb begin
        win_idx = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx = IDXW'(i);
            end
        end
    end

    // Grant sequencing, hold counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= A_IDLE;
            hold_idx  <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                A_IDLE: begin
                    if (|elig) begin
                        state     <= A_GRANT;
                        hold_idx  <= win_idx;
                        grant     <= NPROC'(1) << win_idx;
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                A_GRANT: begin
                    if (holder_rel || !holder_req) begin
                        state     <= A_RELEASE;
                        grant     <= '0;
                        grant_idx <= '0;
                        busy      <= 1'b0;
                    end else if (hold_cnt == CW'(MAXHOLD - 1)) begin
                        // Holder overstayed: take the resource away and flag it.
                        state     <= A_RELEASE;
                        grant     <= '0;
                        grant_idx <= '0;
                        busy      <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + 1'b1;
                    end
                end
                A_RELEASE: begin
                    state <= A_IDLE;
                end
                default: begin
                    state <= A_IDLE;
                end
            endcase
        end
    end

    // The resource enable must never reach two requesters at once.
    assert property (@(posedge clock) disable iff (!reset_n) $onehot0(grant));
    // Grant and busy always move together.
    assert property (@(posedge clock) disable iff (!reset_n) (|grant) == busy);

endmodule

// File: doc/bakery_grant_arbiter.md
Name: bakery_grant_arbiter

Overview:
- Hardware mutual-exclusion arbiter that grants one shared critical resource to NPROC requesters in ticket order.
- Uses a finite age matrix instead of numeric tickets: each requester records which others already held tickets when it took its own.
- Ties between equal-age tickets go to the lower index.
- Sits in front of any shared resource in the bakery models; its grant output is the only enable for that resource.

Parameters:
- NPROC, 3: number of requesters, indices 0..NPROC-1.
- IDXW, 2: index width; requires NPROC <= 2**IDXW.
- MAXHOLD, 8: maximum grant length in cycles before forced release; must be >= 2.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NPROC  level request per requester.
- rel  in  NPROC  release pulse from the grant holder.
- grant  out  NPROC  registered grant, one-hot or zero.
- grant_idx  out  IDXW  holder index; valid while busy=1, otherwise 0.
- busy  out  1  grant outstanding.
- ticket  out  NPROC  registered ticket-holding flags.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, reset_n=0) clears everything:
  - ticket, defer matrix, served flags, hold counter: 0.
  - state: A_IDLE.
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - Reset mid-grant drops grant immediately, with no release sequence.
- Per-requester storage:
  - ticket[i].
  - defer[i][0..NPROC-1]: defer[i][k]=1 means i yields to the older ticket k.
  - served[i].
- clr mask:
  - One bit per requester, marks who leaves this edge.
  - clr[i]=1 on withdraw: req[i]=0 and ticket[i]=1 and i is not the holder.
  - clr[h]=1 for the holder h in A_RELEASE.
- Ticket take, at a given edge:
  - Condition: req[i]=1, ticket[i]=0, served[i]=0.
  - Effect: ticket[i]<=1 and defer[i]<=ticket & ~clr & ~(1<<i).
  - Simultaneous takers snapshot the same pre-edge vector, so they are equal age.
- Leave, when clr[i]=1 at an edge:
  - ticket[i]<=0, row defer[i]<=0.
  - Column defer[*][i]<=0; column clearing overrides any same-edge snapshot bit.
- served[i]:
  - Set when i is released (normal or timeout).
  - Cleared on any edge where req[i]=0.
  - Effect: a requester must drop req for at least 1 cycle before it can take a new ticket.
- Eligibility (combinational on registered state):
  - elig[i] = ticket[i] AND, for every k!=i, NOT(ticket[k] AND (defer[i][k] OR (NOT defer[k][i] AND k<i))).
  - At most one bit set; exactly one whenever ticket is nonzero.
- FSM, arb_state_t:
  - A_IDLE: if elig is nonzero, go to A_GRANT; h<=winner, grant<=1<<h, busy<=1, counter<=0.
  - A_GRANT, exit to A_RELEASE when either holds:
    - rel[h]=1 or req[h]=0 (normal release).
    - counter==MAXHOLD-1 (forced release; timeout<=1 for exactly one cycle).
  - A_GRANT, otherwise: counter++.
  - rel bits of non-holders are ignored.
  - A_RELEASE: grant<=0, busy<=0, grant_idx<=0; clear h per the leave rules; served[h]<=1; go to A_IDLE.
- Latency and throughput:
  - Request to grant: req seen at edge t sets the ticket; grant is high after edge t+1 when idle.
  - Hand-off gap: grant is low for exactly 2 cycles (A_RELEASE, then A_IDLE).
  - Maximum grant duration: MAXHOLD cycles.
- Simultaneous events in one edge must all resolve correctly:
  - Take, withdraw and release.
  - The holder's req dropping together with rel.

Decomposition:
- bakery_pkg holds:
  - typedef enum arb_state_t {A_IDLE, A_GRANT, A_RELEASE}.
  - Default constants for NPROC and MAXHOLD.
- Sub-module bakery_age_matrix:
  - Holds ticket, defer and served.
  - Takes req and clr; produces ticket and elig.
- bakery_grant_arbiter holds the FSM, the holder index, the hold counter and the outputs.

Test Plan:
All scenarios use NPROC=3, MAXHOLD=8.
- Single request: req=3'b010 before edge 0 -> ticket=3'b010 after edge 0; grant=3'b010, grant_idx=1, busy=1 after edge 1.
- Simultaneous requests: req=3'b101 at the same edge -> grant 3'b001 first; after rel[0], grant 3'b100 two cycles after grant falls.
- Age order beats index: 1 holds; req[2] at edge 5, req[0] at edge 6 -> after 1 releases, 2 is granted before 0.
- Timeout: holder 0 keeps req high with rel=0 -> grant high exactly 8 cycles, then timeout=1 for one cycle, grant=0; no new ticket for 0 until req[0] is low for 1 cycle.
- Withdraw in the same edge as a new take:
  - Setup: 1 holds; 2 waits.
  - Stimulus: req[2] drops at the same edge req[0] rises; then req[2] re-asserts.
  - Check: defer[0][2]=0.
  - Required response: after 1 releases, 0 is granted before 2.
- Reset mid-grant: reset_n=0 while grant=3'b100 -> grant, ticket, busy, timeout all 0 immediately; after reset release, the first request is granted with normal latency.
